// File: rtl/slice_add_sequencer.sv
// Multi-cycle wide adder: one shared SLICE-bit ripple slice walks LSB to MSB,
// with the inter-slice carry held in a register and valid/ready on both sides.

module slice_ripple_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);
  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = c[W];
  // Carry into the top bit, needed for signed overflow on the last slice.
  assign c_msb_o = c[W-1];
endmodule

module slice_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_c, sl_cmsb;

  assign sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign sl_b = b_q[int'(idx_q)*SLICE +: SLICE];

  slice_ripple_adder #(.W(SLICE)) u_slice (
    .a_i     (sl_a),
    .b_i     (sl_b),
    .c_i     (carry_q),
    .s_o     (sl_s),
    .c_o     (sl_c),
    .c_msb_o (sl_cmsb)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = sl_s;
        carry_d = sl_c;
        if (idx_q == LAST_IDX) begin
          cout_d  = sl_c;
          ovf_d   = sl_c ^ sl_cmsb;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_slice_add_sequencer.sv
// Self-checking bench for slice_add_sequencer: directed plan cases plus random
// operands against a plain-arithmetic reference model.

module tb_slice_add_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests  = 0;
  int failed = 0;

  slice_add_sequencer #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from integer addition and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0] t;
    logic       v;
    t = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    v = (ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]);
    return {v, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; hold = cycles of out_ready=0 in DONE with noisy inputs.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input int hold, input string tag);
    logic [W+1:0] e;
    int n;
    e = model(ta, tb_v, tc);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      if (!out_valid) n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd4);
    check({tag, ".sum"},  32'(sum),  32'(e[W-1:0]));
    check({tag, ".cout"}, 32'(cout), 32'(e[W]));
    check({tag, ".ovf"},  32'(ovf),  32'(e[W+1]));
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom);
      tick();
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_res"}, {14'd0, ovf, cout, sum}, {14'd0, e});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".release_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] ba[3], bb[3];
  logic         bc[3];
  logic [W+1:0] bexp;
  int           acc_cyc[3];
  int           k, res, seen;
  logic         acc, got;
  logic [W+1:0] got_val;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout_ovf", {30'd0, cout, ovf}, 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ripple1");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "ripple2");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
    run_op(16'h8000, 16'h8000, 1'b0, 0, "ovf_neg");
    run_op(16'h0F0F, 16'h7070, 1'b1, 3, "backpressure");

    // Reset after two slices of work.
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset.out_valid", 32'(out_valid), 32'd0);
    check("midreset.sum", 32'(sum), 32'd0);
    check("midreset.in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midreset.no_result", 32'(seen), 32'd0);
    run_op(16'hAAAA, 16'h5556, 1'b0, 0, "after_reset");

    for (int r = 0; r < 8; r++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");

    // Back-to-back with both handshakes held high.
    for (int i = 0; i < 3; i++) begin
      ba[i] = W'($urandom); bb[i] = W'($urandom); bc[i] = 1'($urandom);
    end
    k = 0; res = 0;
    in_valid = 1'b1; out_ready = 1'b1; a = ba[0]; b = bb[0]; cin = bc[0];
    for (int cyc = 0; cyc < 60 && res < 3; cyc++) begin
      acc = in_ready && in_valid;
      got = out_valid && out_ready;
      got_val = {ovf, cout, sum};
      tick();
      if (acc && k < 3) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) begin
          a = ba[k]; b = bb[k]; cin = bc[k];
        end else begin
          in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        end
      end
      if (got && res < 3) begin
        bexp = model(ba[res], bb[res], bc[res]);
        check("b2b.result", {14'd0, got_val}, {14'd0, bexp});
        res++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.accepts", 32'(k), 32'd3);
    check("b2b.results", 32'(res), 32'd3);
    if (k == 3) begin
      check("b2b.spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      check("b2b.spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
